// File: rtl/fifo2axis_pkg.sv
// fifo2axis_pkg: FSM state encoding and output-buffer depth shared by fifo2axis
// and its output buffer.
package fifo2axis_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int unsigned SKID_DEPTH = 2;

endpackage

// File: rtl/fifo2axis_skid.sv
// fifo2axis_skid: 2-entry output buffer between the FIFO read pipeline and the
// AXI4-Stream master. It pushes on capture, pops on handshake, and exposes the head word.
module fifo2axis_skid
   import fifo2axis_pkg::*;
#(
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk_i,
   input  logic              cke_i,
   input  logic              arst_n_i,
   input  logic              rst_i,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] head_data,
   output logic [1:0]        occ
);

   logic [DATA_W-1:0] mem_q [SKID_DEPTH];
   logic              wr_ptr_q;
   logic              rd_ptr_q;
   logic [1:0]        occ_q;

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         for (int unsigned i = 0; i < SKID_DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         occ_q    <= '0;
      end else if (rst_i) begin
         for (int unsigned i = 0; i < SKID_DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         occ_q    <= '0;
      end else if (cke_i) begin
         if (push) begin
            mem_q[wr_ptr_q] <= push_data;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop) rd_ptr_q <= ~rd_ptr_q;
         case ({push, pop})
            2'b10:   occ_q <= occ_q + 2'd1;
            2'b01:   occ_q <= occ_q - 2'd1;
            default: occ_q <= occ_q;
         endcase
      end
   end

   assign head_data = mem_q[rd_ptr_q];
   assign occ       = occ_q;

endmodule

// File: rtl/fifo2axis.sv
// fifo2axis: drains a 1-cycle-latency synchronous FIFO into an AXI4-Stream master
// for a programmed frame length. Optional FIFO2AXIS_CNT_EN adds count_o.
module fifo2axis
   import fifo2axis_pkg::*;
#(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned AXIS_LEN_W = 16
) (
   input  logic                  clk_i,
   input  logic                  cke_i,
   input  logic                  arst_n_i,
   input  logic                  rst_i,
   input  logic                  en_i,
   input  logic [AXIS_LEN_W-1:0] len_i,
   output logic                  done_o,
   input  logic                  fifo_empty_i,
   output logic                  fifo_read_o,
   input  logic [DATA_W-1:0]     fifo_rdata_i,
   output logic [DATA_W-1:0]     axis_tdata_o,
   output logic                  axis_tvalid_o,
   input  logic                  axis_tready_i,
   output logic                  axis_tlast_o
`ifdef FIFO2AXIS_CNT_EN
   ,
   output logic [AXIS_LEN_W-1:0] count_o
`endif
);

   state_t                state_q;
   state_t                state_d;
   logic                  en_q;
   logic                  start;
   logic [AXIS_LEN_W-1:0] len_q;
   logic [AXIS_LEN_W-1:0] last_idx;
   logic [AXIS_LEN_W-1:0] rd_cnt_q;
   logic [AXIS_LEN_W-1:0] tx_cnt_q;
   logic                  rd_pend_q;
   logic [1:0]            occ;
   logic                  beat;
   logic [2:0]            in_flight;
   logic [2:0]            credit;

   assign start    = en_i & ~en_q;
   assign last_idx = len_q - AXIS_LEN_W'(1);

   fifo2axis_skid #(
      .DATA_W (DATA_W)
   ) u_skid (
      .clk_i     (clk_i),
      .cke_i     (cke_i),
      .arst_n_i  (arst_n_i),
      .rst_i     (rst_i),
      .push      (rd_pend_q),
      .push_data (fifo_rdata_i),
      .pop       (beat),
      .head_data (axis_tdata_o),
      .occ       (occ)
   );

   assign axis_tvalid_o = (occ != 2'd0);
   assign axis_tlast_o  = axis_tvalid_o & (tx_cnt_q == last_idx);
   assign beat          = axis_tvalid_o & axis_tready_i;
   assign done_o        = (state_q == ST_DONE);

   // The head leaving this cycle frees its slot before the new word lands two
   // edges later, so counting it as credit keeps 1 word/cycle without overflow.
   assign in_flight = {1'b0, occ} + {2'b00, rd_pend_q};
   assign credit    = 3'(SKID_DEPTH) + {2'b00, beat};

   assign fifo_read_o = cke_i & ~rst_i & (state_q == ST_RUN) & en_i & ~fifo_empty_i
                        & (rd_cnt_q < len_q) & (in_flight < credit);

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i)   state_q <= ST_IDLE;
      else if (rst_i)  state_q <= ST_IDLE;
      else if (cke_i)  state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start) state_d = (len_i == '0) ? ST_DONE : ST_RUN;
         ST_RUN:  if (beat && axis_tlast_o) state_d = ST_DONE;
         ST_DONE: if (!en_i) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         en_q      <= 1'b0;
         len_q     <= '0;
         rd_cnt_q  <= '0;
         tx_cnt_q  <= '0;
         rd_pend_q <= 1'b0;
      end else if (rst_i) begin
         en_q      <= 1'b0;
         len_q     <= '0;
         rd_cnt_q  <= '0;
         tx_cnt_q  <= '0;
         rd_pend_q <= 1'b0;
      end else if (cke_i) begin
         en_q      <= en_i;
         rd_pend_q <= fifo_read_o;
         if (state_q == ST_IDLE && state_d == ST_RUN) begin
            len_q    <= len_i;
            rd_cnt_q <= '0;
            tx_cnt_q <= '0;
         end else begin
            if (fifo_read_o) rd_cnt_q <= rd_cnt_q + AXIS_LEN_W'(1);
            if (beat)        tx_cnt_q <= tx_cnt_q + AXIS_LEN_W'(1);
         end
      end
   end

`ifdef FIFO2AXIS_CNT_EN
   assign count_o = tx_cnt_q;
`endif

endmodule

// File: tb/tb_fifo2axis.sv
// tb_fifo2axis: directed frames against a FIFO model; a negedge monitor scores beats
// against an expectation queue and checks stall stability and buffer credit.
`timescale 1ns/1ps
module tb_fifo2axis;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned LEN_W  = 16;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              last;
   } exp_t;

   logic              clk_i = 1'b0;
   logic              cke_i;
   logic              arst_n_i;
   logic              rst_i;
   logic              en_i;
   logic [LEN_W-1:0]  len_i;
   logic              done_o;
   logic              fifo_empty_i;
   logic              fifo_read_o;
   logic [DATA_W-1:0] fifo_rdata_i = '0;
   logic [DATA_W-1:0] axis_tdata_o;
   logic              axis_tvalid_o;
   logic              axis_tready_i;
   logic              axis_tlast_o;
`ifdef FIFO2AXIS_CNT_EN
   logic [LEN_W-1:0]  count_o;
`endif

   fifo2axis #(
      .DATA_W     (DATA_W),
      .AXIS_LEN_W (LEN_W)
   ) dut (
      .clk_i         (clk_i),
      .cke_i         (cke_i),
      .arst_n_i      (arst_n_i),
      .rst_i         (rst_i),
      .en_i          (en_i),
      .len_i         (len_i),
      .done_o        (done_o),
      .fifo_empty_i  (fifo_empty_i),
      .fifo_read_o   (fifo_read_o),
      .fifo_rdata_i  (fifo_rdata_i),
      .axis_tdata_o  (axis_tdata_o),
      .axis_tvalid_o (axis_tvalid_o),
      .axis_tready_i (axis_tready_i),
      .axis_tlast_o  (axis_tlast_o)
`ifdef FIFO2AXIS_CNT_EN
      ,
      .count_o       (count_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   int unsigned total = 0;
   int unsigned bad   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // FIFO model: 1-cycle read latency, flush drops everything unread
   logic [DATA_W-1:0] fmem [256];
   int unsigned       f_wr = 0;
   int unsigned       f_rd = 0;
   logic              f_flush = 1'b0;
   logic              hold_empty = 1'b0;

   assign fifo_empty_i = hold_empty | (f_rd == f_wr);

   always @(posedge clk_i) begin
      if (f_flush) f_rd <= f_wr;
      else if (fifo_read_o) begin
         fifo_rdata_i <= fmem[f_rd % 256];
         f_rd         <= f_rd + 1;
      end
   end

   // Monitor / scoreboard
   exp_t              exp_q [$];
   int unsigned       cyc = 0;
   int unsigned       outst = 0;
   int unsigned       rd_seen = 0;
   int unsigned       beats = 0;
   int unsigned       rd_cyc [256];
   int unsigned       beat_cyc [256];
   logic              stalled = 1'b0;
   logic [DATA_W-1:0] prev_data = '0;
   logic              prev_last = 1'b0;

   always @(posedge clk_i) cyc <= cyc + 1;

   always @(negedge clk_i) begin
      exp_t e;
      logic hs;
      if (!arst_n_i || rst_i) begin
         outst   = 0;
         stalled = 1'b0;
      end else if (cke_i) begin
         hs = axis_tvalid_o & axis_tready_i;
         if (stalled) begin
            chk("stall_valid", 64'(axis_tvalid_o), 64'd1);
            chk("stall_data", 64'(axis_tdata_o), 64'(prev_data));
            chk("stall_last", 64'(axis_tlast_o), 64'(prev_last));
         end
         if (fifo_read_o) begin
            chk("read_credit", 64'((outst - (hs ? 1 : 0)) < 2), 64'd1);
            rd_cyc[rd_seen % 256] = cyc;
            rd_seen++;
            outst++;
         end
         if (hs) begin
            chk("beat_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk("beat_data", 64'(axis_tdata_o), 64'(e.data));
               chk("beat_last", 64'(axis_tlast_o), 64'(e.last));
            end
            if (outst > 0) outst--;
            beat_cyc[beats % 256] = cyc;
            beats++;
         end
         stalled   = axis_tvalid_o & ~axis_tready_i;
         prev_data = axis_tdata_o;
         prev_last = axis_tlast_o;
      end
   end

   task automatic step(input int unsigned n);
      repeat (n) @(posedge clk_i);
      #2;
   endtask

   task automatic load(input logic [DATA_W-1:0] base, input int unsigned n);
      for (int unsigned i = 0; i < n; i++) begin
         fmem[f_wr % 256] = base + DATA_W'(i);
         f_wr++;
      end
   endtask

   task automatic expect_frame(input logic [DATA_W-1:0] base, input int unsigned n);
      exp_t e;
      for (int unsigned i = 0; i < n; i++) begin
         e.data = base + DATA_W'(i);
         e.last = (i == n - 1);
         exp_q.push_back(e);
      end
   endtask

   task automatic wait_done(input string name, input int unsigned budget);
      int unsigned k = 0;
      while (!done_o && k < budget) begin
         step(1);
         k++;
      end
      chk(name, 64'(done_o), 64'd1);
   endtask

   task automatic flush_fifo();
      f_flush = 1'b1;
      step(1);
      f_flush = 1'b0;
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_done"},  64'(done_o), 64'd0);
      chk({tag, "_read"},  64'(fifo_read_o), 64'd0);
      chk({tag, "_valid"}, 64'(axis_tvalid_o), 64'd0);
      chk({tag, "_last"},  64'(axis_tlast_o), 64'd0);
      chk({tag, "_data"},  64'(axis_tdata_o), 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish at %0t", $time);
      $fatal(1);
   end

   initial begin
      int unsigned r0;
      int unsigned b0;
      int unsigned k;
      logic [3:0]  pat;

      arst_n_i = 1'b0; rst_i = 1'b0; cke_i = 1'b1; en_i = 1'b0;
      len_i = '0; axis_tready_i = 1'b1;
      step(2);
      chk_idle_outputs("reset");
      arst_n_i = 1'b1;
      step(2);

      // len=4, continuous ready
      load(32'hA0, 4);
      expect_frame(32'hA0, 4);
      r0 = rd_seen; b0 = beats;
      len_i = 16'd4; en_i = 1'b1;
      k = 0;
      while (!(axis_tvalid_o && axis_tready_i && axis_tlast_o) && k < 40) begin
         step(1);
         k++;
      end
      chk("t1_tlast_seen", 64'(axis_tvalid_o & axis_tlast_o), 64'd1);
      chk("t1_tlast_data", 64'(axis_tdata_o), 64'hA3);
      chk("t1_done_before", 64'(done_o), 64'd0);
      step(1);
      chk("t1_done_after", 64'(done_o), 64'd1);
      chk("t1_reads", 64'(rd_seen - r0), 64'd4);
      chk("t1_beats", 64'(beats - b0), 64'd4);
      chk("t1_back2back", 64'(beat_cyc[(b0 + 3) % 256] - beat_cyc[b0 % 256]), 64'd3);
      chk("t1_latency", 64'(beat_cyc[b0 % 256] - rd_cyc[r0 % 256]), 64'd2);
`ifdef FIFO2AXIS_CNT_EN
      chk("t1_count", 64'(count_o), 64'd4);
`endif
      step(2);
      chk("t1_done_sticky", 64'(done_o), 64'd1);
      en_i = 1'b0;
      step(1);
      chk("t1_done_clear", 64'(done_o), 64'd0);

      // len=6, ready pattern 1,0,0,1
      load(32'h0, 6);
      expect_frame(32'h0, 6);
      b0 = beats;
      pat = 4'b1001;
      len_i = 16'd6; en_i = 1'b1;
      k = 0;
      while (!done_o && k < 80) begin
         axis_tready_i = pat[k % 4];
         step(1);
         k++;
      end
      chk("t2_done", 64'(done_o), 64'd1);
      chk("t2_beats", 64'(beats - b0), 64'd6);
      axis_tready_i = 1'b1;
      en_i = 1'b0;
      step(2);

      // len=3, FIFO held empty for 5 cycles
      hold_empty = 1'b1;
      load(32'hC0, 3);
      expect_frame(32'hC0, 3);
      b0 = beats;
      len_i = 16'd3; en_i = 1'b1;
      for (int unsigned i = 0; i < 5; i++) begin
         step(1);
         chk("t3_valid_while_empty", 64'(axis_tvalid_o), 64'd0);
         chk("t3_read_while_empty", 64'(fifo_read_o), 64'd0);
      end
      hold_empty = 1'b0;
      wait_done("t3_done", 30);
      chk("t3_beats", 64'(beats - b0), 64'd3);
      en_i = 1'b0;
      step(2);

      // len=0
      load(32'hEE, 2);
      r0 = rd_seen; b0 = beats;
      len_i = 16'd0; en_i = 1'b1;
      step(1);
      chk("t4_done", 64'(done_o), 64'd1);
      step(3);
      chk("t4_no_reads", 64'(rd_seen - r0), 64'd0);
      chk("t4_no_beats", 64'(beats - b0), 64'd0);
      chk("t4_valid", 64'(axis_tvalid_o), 64'd0);
      en_i = 1'b0;
      step(1);
      chk("t4_done_clear", 64'(done_o), 64'd0);
      flush_fifo();

      // len=8, soft reset after 3 beats, then restart
      load(32'h80, 8);
      expect_frame(32'h80, 8);
      b0 = beats;
      len_i = 16'd8; en_i = 1'b1;
      k = 0;
      while (beats - b0 < 3 && k < 40) begin
         step(1);
         k++;
      end
      chk("t5_three_beats", 64'(beats - b0), 64'd3);
      rst_i = 1'b1; en_i = 1'b0;
      exp_q.delete();
      step(1);
      rst_i = 1'b0;
      chk_idle_outputs("t5_after_rst");
      flush_fifo();
      load(32'h90, 8);
      expect_frame(32'h90, 8);
      b0 = beats;
      en_i = 1'b1;
      wait_done("t5_restart_done", 40);
      chk("t5_restart_beats", 64'(beats - b0), 64'd8);
      en_i = 1'b0;
      step(2);

      // async reset mid-frame with clock enable low
      axis_tready_i = 1'b0;
      load(32'hB0, 4);
      expect_frame(32'hB0, 4);
      len_i = 16'd4; en_i = 1'b1;
      step(4);
      chk("t6_valid_pre", 64'(axis_tvalid_o), 64'd1);
      cke_i = 1'b0;
      step(1);
      #1 arst_n_i = 1'b0;
      #1;
      chk_idle_outputs("t6_async");
`ifdef FIFO2AXIS_CNT_EN
      chk("t6_count", 64'(count_o), 64'd0);
`endif
      exp_q.delete();
      en_i = 1'b0;
      step(2);
      flush_fifo();
      arst_n_i = 1'b1; cke_i = 1'b1; axis_tready_i = 1'b1;
      step(2);
      chk("t6_valid_post", 64'(axis_tvalid_o), 64'd0);
      chk("t6_done_post", 64'(done_o), 64'd0);

      chk("exp_queue_empty", 64'(exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
